mac_pe_acc: RTL and testbench
=============================

# mac_pe_acc

Parametrised signed fixed-point multiply-accumulate processing element with a local coefficient RAM and explicit run control. A host loads coefficients through a packed write port, then issues `start` with a vector length. The block streams `ain` samples against RAM entries 0..len-1 and returns one accumulated dot product on a valid/ready result port. It replaces the float-IP MAC PE in the systolic array where a deterministic fixed-point datapath with backpressure is required.

## Interface
- `DATA_W`, 16, width of `ain` and of each RAM entry; signed two's complement
- `L_RAM_SIZE`, 6, log2 of RAM depth in entries
- `ACC_W`, 40, accumulator width; must be ≥ 2*DATA_W
- `OUT_W`, 32, result width; must be ≤ ACC_W
- `OUT_SHIFT`, 0, arithmetic right shift applied to the accumulator before output
- `aclk` in 1: the single clock
- `aresetn` in 1: reset, asynchronous, active-low
- `we` in 1: coefficient write strobe
- `waddr` in L_RAM_SIZE-1: pair address; writes entries 2*waddr (din upper half) and 2*waddr+1 (lower half)
- `din` in 2*DATA_W: packed coefficient pair
- `start` in 1: begin a run
- `len` in L_RAM_SIZE+1: vector length, 1..2**L_RAM_SIZE
- `busy` out 1: high in every state except IDLE
- `ain` in DATA_W: sample
- `ain_valid` in 1 / `ain_ready` out 1: sample handshake
- `dout` out OUT_W: result
- `dvalid` out 1 / `dready` in 1: result handshake
- `sat` out 1: result was clipped (always 0 without saturation)

## Operation
- States: IDLE, RUN, DRAIN, DONE.
- IDLE: `ain_ready`=0. `start` with len≠0 latches len, clears accumulator and index k, and moves to RUN. `start` with len=0 is ignored.
- RUN: `ain_ready`=1. Each transfer (`ain_valid`&&`ain_ready`) pairs ain with entry k, then k++. When the transfer with k=len-1 completes, move to DRAIN.
- DRAIN: lasts 2 cycles, `ain_ready`=0. Then move to DONE.
- DONE: `dvalid`=1. `dout` and `sat` are held stable until `dready`, then move to IDLE.
- Datapath: product is the signed DATA_W×DATA_W product, full 2*DATA_W bits. It is sign-extended to ACC_W and accumulated modulo 2^ACC_W.
- Result: `acc >>> OUT_SHIFT`, keeping the low OUT_W bits.
- RAM writes are accepted only in IDLE and DONE; `we` is ignored in RUN and DRAIN. A write and `start` in the same IDLE cycle are both performed, and the run uses the new data.
- `start` is ignored while busy. `dready` is ignored when `dvalid`=0.
- Reset (any time, including mid-run): state→IDLE. Accumulator, k, `dout`, `dvalid`, `sat`, `ain_ready`, `busy` all go to 0. RAM contents are not reset and are preserved across reset.

## Timing
- `start` sampled at edge E enters RUN; `ain_ready` is high from the cycle after E.
- Pipeline for a transfer at edge T0:
  - T0: `ain` registered and RAM read of entry k.
  - T0+1: product registered.
  - T0+2: accumulator updated.
  - T0+3: `dout`/`dvalid` registered.
- Last transfer at T0 → `dvalid` high after T0+3.
- Minimum run length: len throughput cycles + 3 cycles to result.
- Gaps in `ain_valid` stall only the input stage; pipeline bubbles carry no accumulate enable.

## Configuration
- `MAC_PE_SAT_EN` defined: if the shifted accumulator is outside the signed OUT_W range, `dout` is clamped to 2^(OUT_W-1)-1 or -2^(OUT_W-1) and `sat`=1.
- `MAC_PE_SAT_EN` undefined: low OUT_W bits, wrap-around; `sat` is tied 0.

## Structure
- `mac_pe_pkg`: state enum, and a function checking that parameters are legal (ACC_W ≥ 2*DATA_W, OUT_W ≤ ACC_W).
- Sub-module `mac_pe_ram`: single-port block RAM with packed pair write and registered single-entry read.

## Test plan
- Basic dot product: write din=0x0003_0002 at waddr 0; len=2; ain 4 then 5 → dout=22 (0x00000016), dvalid 3 cycles after last transfer.
- Backpressure: same as basic, with 3 idle cycles between samples → dout=22. `ain_ready`=0 in IDLE, DRAIN and DONE.
- Signed: entry 0 = 0xFFFF; len=1; ain=0x7FFF → dout=0xFFFF8001.
- Overflow: len=64, all entries and samples 0x7FFF.
  - With `MAC_PE_SAT_EN`: dout=0x7FFFFFFF, sat=1.
  - Without: dout=0xFFC00040, sat=0.
- Result hold: `dready` held low 10 cycles → dout stable. `start` ignored; a write is accepted and seen by the next run. `dready`=1 → IDLE next cycle.
- Mid-run reset: assert `aresetn`=0 during RUN → all outputs 0 immediately. Rerun the basic test with no reload → dout=22.

Source files
------------

// File: rtl/mac_pe_pkg.sv
// mac_pe_pkg: shared run-control state encoding and a parameter sanity helper
// for the fixed-point MAC processing element.
package mac_pe_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    // The accumulator must hold a full product and the result must fit in the accumulator.
    function automatic bit params_legal(input int data_w, input int acc_w, input int out_w);
        return (acc_w >= 2 * data_w) && (out_w <= acc_w) && (out_w >= 1);
    endfunction

endpackage

// File: rtl/mac_pe_ram.sv
// mac_pe_ram: single-port coefficient RAM. Writes store a packed pair
// (upper half -> even entry, lower half -> odd entry); reads return one
// entry through an output register.
module mac_pe_ram
    import mac_pe_pkg::*;
#(
    parameter int DATA_W     = 16,
    parameter int L_RAM_SIZE = 6
) (
    input  logic                    clk,
    input  logic                    we,
    input  logic [L_RAM_SIZE-2:0]   waddr,
    input  logic [2*DATA_W-1:0]     wdata,
    input  logic                    re,
    input  logic [L_RAM_SIZE-1:0]   raddr,
    output logic [DATA_W-1:0]       rdata
);

    localparam int PAIRS = 2 ** (L_RAM_SIZE - 1);

    logic [2*DATA_W-1:0]   mem [PAIRS];
    logic [L_RAM_SIZE-2:0] addr;
    logic [2*DATA_W-1:0]   word;
    logic [DATA_W-1:0]     rdata_q;

    // One shared address port: the owner never writes and reads in the same cycle.
    assign addr  = we ? waddr : raddr[L_RAM_SIZE-1:1];
    assign word  = mem[addr];
    assign rdata = rdata_q;

    // Storage is deliberately not reset so coefficients survive a reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        if (re) begin
            rdata_q <= raddr[0] ? word[DATA_W-1:0] : word[2*DATA_W-1:DATA_W];
        end
    end

endmodule

// File: rtl/mac_pe_acc.sv
// mac_pe_acc: signed fixed-point multiply-accumulate PE with a local
// coefficient RAM, start/len run control and a valid/ready result port.
// Optional build macro MAC_PE_SAT_EN: clamp the result to the signed OUT_W
// range and flag clipping on sat; without it the result wraps and sat is 0.
module mac_pe_acc
    import mac_pe_pkg::*;
#(
    parameter int DATA_W     = 16,
    parameter int L_RAM_SIZE = 6,
    parameter int ACC_W      = 40,
    parameter int OUT_W      = 32,
    parameter int OUT_SHIFT  = 0
) (
    input  logic                    aclk,
    input  logic                    aresetn,
    input  logic                    we,
    input  logic [L_RAM_SIZE-2:0]   waddr,
    input  logic [2*DATA_W-1:0]     din,
    input  logic                    start,
    input  logic [L_RAM_SIZE:0]     len,
    output logic                    busy,
    input  logic [DATA_W-1:0]       ain,
    input  logic                    ain_valid,
    output logic                    ain_ready,
    output logic [OUT_W-1:0]        dout,
    output logic                    dvalid,
    input  logic                    dready,
    output logic                    sat
);

    localparam int PROD_W = 2 * DATA_W;

    if (!params_legal(DATA_W, ACC_W, OUT_W)) begin : g_param_check
        $error("mac_pe_acc: illegal DATA_W/ACC_W/OUT_W combination");
    end

    state_e                    state_q, state_d;
    logic [L_RAM_SIZE:0]       len_q, len_d;
    logic [L_RAM_SIZE-1:0]     k_q, k_d;
    logic                      drain_q, drain_d;
    logic [DATA_W-1:0]         ain_q, ain_d;
    logic                      v1_q, v1_d;
    logic signed [PROD_W-1:0]  prod_q, prod_d;
    logic                      v2_q, v2_d;
    logic signed [ACC_W-1:0]   acc_q, acc_d;
    logic [OUT_W-1:0]          dout_q, dout_d;
    logic                      dvalid_q, dvalid_d;
    logic                      sat_q, sat_d;

    logic [DATA_W-1:0]         coef;
    logic                      xfer;
    logic                      last_xfer;
    logic                      launch;
    logic                      ram_we;
    logic                      load_res;
    logic signed [ACC_W-1:0]   shifted;
    logic [OUT_W-1:0]          res_val;
    logic                      res_sat;

    assign xfer      = (state_q == ST_RUN) && ain_valid;
    assign last_xfer = xfer && ({1'b0, k_q} == (len_q - (L_RAM_SIZE + 1)'(1)));
    assign launch    = (state_q == ST_IDLE) && start && (len != '0);
    assign ram_we    = we && ((state_q == ST_IDLE) || (state_q == ST_DONE));
    assign load_res  = (state_q == ST_DONE) && !dvalid_q;
    assign shifted   = acc_q >>> OUT_SHIFT;

    assign busy      = (state_q != ST_IDLE);
    assign ain_ready = (state_q == ST_RUN);
    assign dout      = dout_q;
    assign dvalid    = dvalid_q;
    assign sat       = sat_q;

    mac_pe_ram #(
        .DATA_W     (DATA_W),
        .L_RAM_SIZE (L_RAM_SIZE)
    ) u_ram (
        .clk   (aclk),
        .we    (ram_we),
        .waddr (waddr),
        .wdata (din),
        .re    (xfer),
        .raddr (k_q),
        .rdata (coef)
    );

`ifdef MAC_PE_SAT_EN
    logic [ACC_W-OUT_W:0] hi_bits;
    logic                 in_range;

    // Clamp to the signed OUT_W range when the shifted accumulator does not fit.
    always_comb begin
        hi_bits  = shifted[ACC_W-1:OUT_W-1];
        in_range = (&hi_bits) || (~|hi_bits);
        res_sat  = !in_range;
        res_val  = shifted[OUT_W-1:0];
        if (!in_range) begin
            res_val = shifted[ACC_W-1] ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}};
        end
    end
`else
    logic unused_hi;

    // Plain wrap-around: keep only the low OUT_W bits of the shifted accumulator.
    always_comb begin
        unused_hi = ^shifted[ACC_W-1:OUT_W];
        res_val   = shifted[OUT_W-1:0];
        res_sat   = 1'b0;
    end
`endif

    // Run control: walk k over the vector, then let the pipeline drain before presenting the result.
    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        k_d     = k_q;
        drain_d = drain_q;
        case (state_q)
            ST_IDLE: begin
                if (launch) begin
                    len_d   = len;
                    k_d     = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (xfer) begin
                    k_d = k_q + L_RAM_SIZE'(1);
                end
                if (last_xfer) begin
                    drain_d = 1'b0;
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                drain_d = 1'b1;
                if (drain_q) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (dvalid_q && dready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Datapath: sample register, full-width signed product, then sign-extended accumulation.
    always_comb begin
        ain_d  = xfer ? ain : ain_q;
        v1_d   = xfer;
        prod_d = prod_q;
        if (v1_q) begin
            prod_d = PROD_W'($signed(ain_q)) * PROD_W'($signed(coef));
        end
        v2_d  = v1_q;
        acc_d = acc_q;
        if (launch) begin
            acc_d = '0;
        end else if (v2_q) begin
            acc_d = acc_q + ACC_W'(prod_q);
        end
    end

    // Result port: capture once on entering DONE and hold until the consumer takes it.
    always_comb begin
        dout_d   = dout_q;
        sat_d    = sat_q;
        dvalid_d = dvalid_q;
        if (load_res) begin
            dout_d   = res_val;
            sat_d    = res_sat;
            dvalid_d = 1'b1;
        end else if (dvalid_q && dready) begin
            dvalid_d = 1'b0;
        end
    end

    // All control and datapath registers clear on reset; the RAM is left untouched.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q  <= ST_IDLE;
            len_q    <= '0;
            k_q      <= '0;
            drain_q  <= 1'b0;
            ain_q    <= '0;
            v1_q     <= 1'b0;
            prod_q   <= '0;
            v2_q     <= 1'b0;
            acc_q    <= '0;
            dout_q   <= '0;
            dvalid_q <= 1'b0;
            sat_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            len_q    <= len_d;
            k_q      <= k_d;
            drain_q  <= drain_d;
            ain_q    <= ain_d;
            v1_q     <= v1_d;
            prod_q   <= prod_d;
            v2_q     <= v2_d;
            acc_q    <= acc_d;
            dout_q   <= dout_d;
            dvalid_q <= dvalid_d;
            sat_q    <= sat_d;
        end
    end

endmodule

// File: tb/tb_mac_pe_acc.sv
// tb_mac_pe_acc: directed, table-driven bench for mac_pe_acc with
// hand-written sequences for overflow, result hold and mid-run reset.
module tb_mac_pe_acc;

    logic        aclk;
    logic        aresetn;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] din;
    logic        start;
    logic [6:0]  len;
    logic        busy;
    logic [15:0] ain;
    logic        ain_valid;
    logic        ain_ready;
    logic [31:0] dout;
    logic        dvalid;
    logic        dready;
    logic        sat;

    int testsRun    = 0;
    int testsFailed = 0;

    typedef struct {
        logic [3:0][15:0] coef;
        logic [3:0][15:0] samp;
        int               vlen;
        int               gap;
        logic [31:0]      expDout;
        logic             expSat;
    } vec_t;

    vec_t vecs[5];

    mac_pe_acc #(
        .DATA_W     (16),
        .L_RAM_SIZE (6),
        .ACC_W      (40),
        .OUT_W      (32),
        .OUT_SHIFT  (0)
    ) dut (
        .aclk      (aclk),
        .aresetn   (aresetn),
        .we        (we),
        .waddr     (waddr),
        .din       (din),
        .start     (start),
        .len       (len),
        .busy      (busy),
        .ain       (ain),
        .ain_valid (ain_valid),
        .ain_ready (ain_ready),
        .dout      (dout),
        .dvalid    (dvalid),
        .dready    (dready),
        .sat       (sat)
    );

    // Free-running 100 MHz clock.
    initial begin
        aclk = 1'b0;
        forever #5 aclk = ~aclk;
    end

    // Hard stop in case anything above ever stalls.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    function automatic vec_t mkVec(input logic [15:0] c0, input logic [15:0] c1,
                                   input logic [15:0] c2, input logic [15:0] c3,
                                   input logic [15:0] s0, input logic [15:0] s1,
                                   input logic [15:0] s2, input logic [15:0] s3,
                                   input int vlen, input int gap,
                                   input logic [31:0] expDout, input logic expSat);
        vec_t v;
        v.coef[0] = c0; v.coef[1] = c1; v.coef[2] = c2; v.coef[3] = c3;
        v.samp[0] = s0; v.samp[1] = s1; v.samp[2] = s2; v.samp[3] = s3;
        v.vlen    = vlen;
        v.gap     = gap;
        v.expDout = expDout;
        v.expSat  = expSat;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: actual=0x%0h required=0x%0h", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic writePair(input logic [4:0] addr, input logic [31:0] data);
        we    = 1'b1;
        waddr = addr;
        din   = data;
        tick();
        we    = 1'b0;
    endtask

    task automatic startRun(input string name, input int n);
        checkOutput({name, " idle ain_ready"}, 64'(ain_ready), 64'd0);
        start = 1'b1;
        len   = 7'(n);
        tick();
        start = 1'b0;
        checkOutput({name, " run ain_ready"}, 64'(ain_ready), 64'd1);
        checkOutput({name, " run busy"}, 64'(busy), 64'd1);
    endtask

    task automatic sendSample(input logic [15:0] val, input int gap);
        ain_valid = 1'b0;
        repeat (gap) tick();
        ain_valid = 1'b1;
        ain       = val;
        tick();
        ain_valid = 1'b0;
    endtask

    // Called right after the last transfer edge: checks DRAIN, latency to dvalid and the result.
    task automatic waitResult(input string name, input logic [31:0] expDout, input logic expSat);
        int cnt;
        checkOutput({name, " drain ain_ready"}, 64'(ain_ready), 64'd0);
        checkOutput({name, " drain busy"}, 64'(busy), 64'd1);
        cnt = 0;
        while (dvalid !== 1'b1 && cnt < 20) begin
            tick();
            cnt++;
        end
        checkOutput({name, " latency"}, 64'(cnt), 64'd3);
        checkOutput({name, " dout"}, 64'(dout), 64'(expDout));
        checkOutput({name, " sat"}, 64'(sat), 64'(expSat));
        checkOutput({name, " done ain_ready"}, 64'(ain_ready), 64'd0);
    endtask

    task automatic ackResult(input string name);
        dready = 1'b1;
        tick();
        dready = 1'b0;
        checkOutput({name, " ack busy"}, 64'(busy), 64'd0);
        checkOutput({name, " ack dvalid"}, 64'(dvalid), 64'd0);
    endtask

    task automatic applyStimulus(input vec_t v, input int id);
        string name;
        name = $sformatf("vec%0d", id);
        writePair(5'd0, {v.coef[0], v.coef[1]});
        writePair(5'd1, {v.coef[2], v.coef[3]});
        startRun(name, v.vlen);
        for (int i = 0; i < v.vlen; i++) begin
            sendSample(v.samp[i], (i == 0) ? 0 : v.gap);
        end
        waitResult(name, v.expDout, v.expSat);
        ackResult(name);
    endtask

    initial begin
        we        = 1'b0;
        waddr     = '0;
        din       = '0;
        start     = 1'b0;
        len       = '0;
        ain       = '0;
        ain_valid = 1'b0;
        dready    = 1'b0;
        aresetn   = 1'b0;

        vecs[0] = mkVec(16'h0003, 16'h0002, 16'h0000, 16'h0000,
                        16'h0004, 16'h0005, 16'h0000, 16'h0000, 2, 0, 32'h0000_0016, 1'b0);
        vecs[1] = mkVec(16'h0003, 16'h0002, 16'h0000, 16'h0000,
                        16'h0004, 16'h0005, 16'h0000, 16'h0000, 2, 3, 32'h0000_0016, 1'b0);
        vecs[2] = mkVec(16'hFFFF, 16'h0000, 16'h0000, 16'h0000,
                        16'h7FFF, 16'h0000, 16'h0000, 16'h0000, 1, 0, 32'hFFFF_8001, 1'b0);
        vecs[3] = mkVec(16'hFFFE, 16'h0007, 16'h8000, 16'h0001,
                        16'h0003, 16'hFFFC, 16'h0002, 16'h0064, 4, 1, 32'hFFFF_0042, 1'b0);
`ifdef MAC_PE_SAT_EN
        vecs[4] = mkVec(16'h8000, 16'h8000, 16'h0001, 16'h0000,
                        16'h8000, 16'h8000, 16'h7FFF, 16'h0000, 3, 2, 32'h7FFF_FFFF, 1'b1);
`else
        vecs[4] = mkVec(16'h8000, 16'h8000, 16'h0001, 16'h0000,
                        16'h8000, 16'h8000, 16'h7FFF, 16'h0000, 3, 2, 32'h8000_7FFF, 1'b0);
`endif

        // Reset state while reset is held.
        repeat (3) @(posedge aclk);
        #1;
        checkOutput("reset busy", 64'(busy), 64'd0);
        checkOutput("reset ain_ready", 64'(ain_ready), 64'd0);
        checkOutput("reset dvalid", 64'(dvalid), 64'd0);
        checkOutput("reset dout", 64'(dout), 64'd0);
        checkOutput("reset sat", 64'(sat), 64'd0);
        #2 aresetn = 1'b1;
        tick();

        // len=0 start is ignored.
        start = 1'b1;
        len   = 7'd0;
        tick();
        start = 1'b0;
        checkOutput("len0 busy", 64'(busy), 64'd0);

        for (int i = 0; i < 5; i++) begin
            applyStimulus(vecs[i], i);
        end

        // Overflow: full-length run of maximum positive values.
        for (int p = 0; p < 32; p++) begin
            writePair(5'(p), 32'h7FFF_7FFF);
        end
        startRun("ovf", 64);
        for (int i = 0; i < 64; i++) begin
            sendSample(16'h7FFF, 0);
        end
`ifdef MAC_PE_SAT_EN
        waitResult("ovf", 32'h7FFF_FFFF, 1'b1);
`else
        waitResult("ovf", 32'hFFC0_0040, 1'b0);
`endif
        ackResult("ovf");

        // Result hold: dready low, start ignored, write accepted in DONE.
        writePair(5'd0, 32'h0003_0002);
        startRun("hold", 2);
        sendSample(16'd4, 0);
        sendSample(16'd5, 0);
        waitResult("hold", 32'd22, 1'b0);
        for (int c = 0; c < 10; c++) begin
            start = (c == 2);
            len   = 7'd1;
            we    = (c == 4);
            waddr = 5'd0;
            din   = 32'h0001_0001;
            tick();
            checkOutput($sformatf("hold c%0d dout", c), 64'(dout), 64'd22);
            checkOutput($sformatf("hold c%0d dvalid", c), 64'(dvalid), 64'd1);
        end
        start = 1'b0;
        we    = 1'b0;
        ackResult("hold");
        startRun("hold2", 2);
        sendSample(16'd4, 0);
        sendSample(16'd5, 0);
        waitResult("hold2", 32'd9, 1'b0);
        ackResult("hold2");

        // Mid-run reset; a write during RUN must be ignored and RAM must survive reset.
        writePair(5'd0, 32'h0003_0002);
        startRun("mrst", 2);
        sendSample(16'd4, 0);
        writePair(5'd0, 32'hFFFF_FFFF);
        #2 aresetn = 1'b0;
        #1;
        checkOutput("mrst busy", 64'(busy), 64'd0);
        checkOutput("mrst ain_ready", 64'(ain_ready), 64'd0);
        checkOutput("mrst dvalid", 64'(dvalid), 64'd0);
        checkOutput("mrst dout", 64'(dout), 64'd0);
        checkOutput("mrst sat", 64'(sat), 64'd0);
        tick();
        tick();
        #2 aresetn = 1'b1;
        tick();
        startRun("rerun", 2);
        sendSample(16'd4, 0);
        sendSample(16'd5, 0);
        waitResult("rerun", 32'd22, 1'b0);
        ackResult("rerun");

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
